// File: rtl/dmem_pkg.sv
// Shared types, widths and the address-legality check for the multi-cycle data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 32;

    // Misaligned byte address or word index beyond the array is an error.
    function automatic logic dmem_addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, combinational read; contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory with programmable latency: captures one request, stalls the
// pipeline while the access is in flight, then returns a one-cycle ack with data/error.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_we_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic [WORD_W-1:0] req_wdata_q;
    logic              req_err_q;

    logic              capture_c;
    logic              mem_we_c;
    logic              ack_d;
    logic              err_d;
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] arr_rdata;

    // Next-state, counter and response logic; the array is touched only on BUSY->RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        mem_we_c  = 1'b0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_o;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    capture_c = 1'b1;
                    cnt_d     = CNT_W'(LATENCY - 1);
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    err_d   = req_err_q;
                    if (req_err_q) begin
                        rdata_d = '0;
                    end else if (req_we_q) begin
                        mem_we_c = 1'b1;
                    end else begin
                        rdata_d = arr_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_o   <= ack_d;
            err_o   <= err_d;
            rdata_o <= rdata_d;
        end
    end

    // Request is frozen at capture so later changes on the inputs are ignored.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_we_q    <= 1'b0;
            req_idx_q   <= '0;
            req_wdata_q <= '0;
            req_err_q   <= 1'b0;
        end else if (capture_c) begin
            req_we_q    <= we_i;
            req_idx_q   <= addr_i[IDX_W+1:2];
            req_wdata_q <= wdata_i;
            req_err_q   <= dmem_addr_err(addr_i, DEPTH);
        end
    end

    // Combinational in IDLE so the requesting instruction freezes in its first MEM cycle.
    assign stall_o = ((state_q == IDLE) && req_i) || (state_q == BUSY);

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i (clk_i),
        .we    (mem_we_c),
        .idx   (req_idx_q),
        .wdata (req_wdata_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at LATENCY=4 and LATENCY=1.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        stall4, ack4, err4;
    logic [31:0] rdata4;
    logic        stall1, ack1, err1;
    logic [31:0] rdata1;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(4)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .stall_o(stall4), .ack_o(ack4), .rdata_o(rdata4), .err_o(err4)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .stall_o(stall1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1)
    );

    task automatic idle_cycles(input int n);
        req = 1'b0;
        we  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Drives one request on the shared inputs and observes the LATENCY=4 instance.
    task automatic access4(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic seen, output int lat,
                           output logic [31:0] rd, output logic e);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        seen = 1'b0; lat = -1; rd = 'x; e = 1'bx;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (ack4) begin
                seen = 1'b1; lat = k; rd = rdata4; e = err4;
                break;
            end
            @(negedge clk);
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        #12;
        n_total++; if (ack4 !== 1'b0) $display("FAIL reset_ack: got %b expected 0", ack4); else n_pass++;
        n_total++; if (err4 !== 1'b0) $display("FAIL reset_err: got %b expected 0", err4); else n_pass++;
        n_total++; if (rdata4 !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata4); else n_pass++;
        n_total++; if (stall4 !== 1'b0) $display("FAIL reset_stall_idle: got %b expected 0", stall4); else n_pass++;
        req = 1'b1; #1;
        n_total++; if (stall4 !== 1'b1) $display("FAIL reset_stall_follows_req: got %b expected 1", stall4); else n_pass++;
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        int stall_cnt = 0, ack_cnt = 0, ack_at = -1;
        logic stall_first = 1'b0;
        logic [31:0] rd = 'x;
        logic e = 1'bx;
        dut4.u_array.mem[8] = 32'hDEADBEEF;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h20; wdata = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k == 0) stall_first = stall4;
            if (stall4) stall_cnt++;
            if (ack4) begin
                ack_cnt++;
                if (ack_at < 0) ack_at = k;
                rd = rdata4; e = err4; req = 1'b0;
            end
            @(negedge clk);
        end
        n_total++; if (stall_first !== 1'b1) $display("FAIL load_stall_first: got %b expected 1", stall_first); else n_pass++;
        n_total++; if (stall_cnt != 5) $display("FAIL load_stall_cycles: got %0d expected 5", stall_cnt); else n_pass++;
        n_total++; if (ack_cnt != 1 || ack_at != 5) $display("FAIL load_ack: got %0d acks at %0d expected 1 at 5", ack_cnt, ack_at); else n_pass++;
        n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h expected deadbeef", rd); else n_pass++;
        n_total++; if (e !== 1'b0) $display("FAIL load_err: got %b expected 0", e); else n_pass++;
    endtask

    task automatic test_store_load();
        logic seen, e;
        int lat;
        logic [31:0] rd;
        access4(1'b1, 32'h40, 32'h12345678, seen, lat, rd, e);
        n_total++; if (!seen || lat != 5) $display("FAIL store_ack: got seen=%b lat=%0d expected seen=1 lat=5", seen, lat); else n_pass++;
        n_total++; if (e !== 1'b0) $display("FAIL store_err: got %b expected 0", e); else n_pass++;
        n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL store_rdata_hold: got %h expected deadbeef", rd); else n_pass++;
        access4(1'b0, 32'h40, 32'h0, seen, lat, rd, e);
        n_total++; if (!seen || lat != 5) $display("FAIL load_after_store_ack: got seen=%b lat=%0d expected seen=1 lat=5", seen, lat); else n_pass++;
        n_total++; if (rd !== 32'h12345678) $display("FAIL load_after_store_rdata: got %h expected 12345678", rd); else n_pass++;
    endtask

    task automatic test_errors();
        logic seen, e;
        int lat;
        logic [31:0] rd;
        access4(1'b0, 32'h22, 32'h0, seen, lat, rd, e);
        n_total++; if (e !== 1'b1) $display("FAIL misaligned_err: got %b expected 1", e); else n_pass++;
        n_total++; if (rd !== 32'h0) $display("FAIL misaligned_rdata: got %h expected 0", rd); else n_pass++;
        dut4.u_array.mem[0] = 32'hCAFEF00D;
        access4(1'b1, 32'h1000, 32'h11111111, seen, lat, rd, e);
        n_total++; if (!seen || e !== 1'b1) $display("FAIL range_store_err: got seen=%b err=%b expected 1/1", seen, e); else n_pass++;
        access4(1'b0, 32'h0, 32'h0, seen, lat, rd, e);
        n_total++; if (rd !== 32'hCAFEF00D || e !== 1'b0) $display("FAIL range_word0_kept: got %h err=%b expected cafef00d err=0", rd, e); else n_pass++;
        dut4.u_array.mem[1023] = 32'h0BADC0DE;
        access4(1'b0, 32'hFFC, 32'h0, seen, lat, rd, e);
        n_total++; if (e !== 1'b0) $display("FAIL last_word_err: got %b expected 0", e); else n_pass++;
        n_total++; if (rd !== 32'h0BADC0DE) $display("FAIL last_word_rdata: got %h expected 0badc0de", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] obs_stall = '0, obs_ack = '0;
        logic [31:0] rd_a = 'x, rd_b = 'x;
        logic e_a = 1'bx;
        idle_cycles(8);
        dut1.u_array.mem[8] = 32'h0A0A0A0A;
        dut1.u_array.mem[9] = 32'h0B0B0B0B;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h20; wdata = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            obs_stall[k] = stall1;
            obs_ack[k]   = ack1;
            if (k == 2) begin rd_a = rdata1; e_a = err1; addr = 32'h24; end
            if (k == 5) begin rd_b = rdata1; req = 1'b0; end
            @(negedge clk);
        end
        n_total++; if (obs_stall !== 6'b011011) $display("FAIL b2b_stall: got %b expected 011011", obs_stall); else n_pass++;
        n_total++; if (obs_ack !== 6'b100100) $display("FAIL b2b_ack: got %b expected 100100", obs_ack); else n_pass++;
        n_total++; if (rd_a !== 32'h0A0A0A0A || e_a !== 1'b0) $display("FAIL b2b_first: got %h err=%b expected 0a0a0a0a err=0", rd_a, e_a); else n_pass++;
        n_total++; if (rd_b !== 32'h0B0B0B0B) $display("FAIL b2b_second: got %h expected 0b0b0b0b", rd_b); else n_pass++;
    endtask

    task automatic test_reset_busy();
        logic seen, e;
        int lat;
        logic [31:0] rd;
        logic ack_seen = 1'b0;
        idle_cycles(8);
        dut4.u_array.mem[4] = 32'h44444444;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hAAAA5555;
        repeat (2) @(negedge clk);
        #1;
        n_total++; if (stall4 !== 1'b1) $display("FAIL rstbusy_stall_before: got %b expected 1", stall4); else n_pass++;
        rst_n = 1'b0; req = 1'b0; we = 1'b0;
        #1;
        n_total++; if (stall4 !== 1'b0) $display("FAIL rstbusy_stall: got %b expected 0", stall4); else n_pass++;
        n_total++; if (rdata4 !== 32'h0) $display("FAIL rstbusy_rdata: got %h expected 0", rdata4); else n_pass++;
        n_total++; if (err4 !== 1'b0) $display("FAIL rstbusy_err: got %b expected 0", err4); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (ack4) ack_seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (ack4) ack_seen = 1'b1;
        end
        n_total++; if (ack_seen !== 1'b0) $display("FAIL rstbusy_no_ack: got %b expected 0", ack_seen); else n_pass++;
        access4(1'b0, 32'h10, 32'h0, seen, lat, rd, e);
        n_total++; if (!seen || lat != 5) $display("FAIL rstbusy_fresh_ack: got seen=%b lat=%0d expected seen=1 lat=5", seen, lat); else n_pass++;
        n_total++; if (rd !== 32'h44444444) $display("FAIL rstbusy_word4_kept: got %h expected 44444444", rd); else n_pass++;
        n_total++; if (e !== 1'b0) $display("FAIL rstbusy_fresh_err: got %b expected 0", e); else n_pass++;
    endtask

    task automatic test_req_change();
        logic seen = 1'b0;
        logic [31:0] rd = 'x;
        idle_cycles(8);
        dut4.u_array.mem[9] = 32'h99999999;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h20; wdata = '0;
        @(negedge clk);
        addr = 32'h24;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (ack4) begin seen = 1'b1; rd = rdata4; break; end
            @(negedge clk);
        end
        req = 1'b0;
        n_total++; if (seen !== 1'b1) $display("FAIL change_ack: got %b expected 1", seen); else n_pass++;
        n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL change_rdata: got %h expected deadbeef", rd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_load();
        test_errors();
        test_back_to_back();
        test_reset_busy();
        test_req_change();
        idle_cycles(4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
